// File: rtl/pong_game_core.sv
// Pong game engine: key buffer, game FSM, ball/paddle physics, scoring and a
// registered per-pixel colour generator for the VGA path.
module pong_game_core #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_W   = 64,
    parameter int PADDLE_H   = 8,
    parameter int BALL_SIZE  = 8,
    parameter int BORDER     = 6,
    parameter int FEATURE    = 11,
    parameter int WIN_SCORE  = 9,
    parameter int SPEED_INIT = 5,
    parameter int SPEED_MIN  = 1,
    parameter int CPU_PERIOD = 4,
    parameter int COLOR_W    = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               key_valid,
    input  logic [7:0]         key_code,
    input  logic               active_zone,
    input  logic [9:0]         x_pos,
    input  logic [9:0]         y_pos,
    output logic [COLOR_W-1:0] color,
    output logic [3:0]         score_p1,
    output logic [3:0]         score_p2,
    output logic [2:0]         state,
    output logic               game_over
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StSelect = 3'd1,
        StPlay   = 3'd2,
        StPause  = 3'd3,
        StScored = 3'd4,
        StOver   = 3'd5
    } state_e;

    localparam logic [7:0] KeyD     = 8'h23;
    localparam logic [7:0] KeyA     = 8'h1C;
    localparam logic [7:0] KeyL     = 8'h4B;
    localparam logic [7:0] KeyJ     = 8'h3B;
    localparam logic [7:0] KeySpace = 8'h29;
    localparam logic [7:0] KeyEsc   = 8'h76;
    localparam logic [7:0] KeyOne   = 8'h16;
    localparam logic [7:0] KeyTwo   = 8'h1E;

    localparam int HalfPw   = PADDLE_W / 2;
    localparam int HalfPh   = PADDLE_H / 2;
    localparam int HalfBall = BALL_SIZE / 2;
    localparam int CenX     = SCREEN_W / 2;
    localparam int CenY     = SCREEN_H / 2;
    localparam int P1Y      = SCREEN_H - 4 * BORDER;
    localparam int P2Y      = 4 * BORDER;
    localparam int PadMin   = FEATURE + BALL_SIZE + HalfPw;
    localparam int PadMax   = SCREEN_W - FEATURE - BALL_SIZE - HalfPw;
    localparam int CpuMin   = FEATURE + BORDER + HalfPw;
    localparam int CpuMax   = SCREEN_W - FEATURE - BORDER - HalfPw;
    localparam int BallMin  = FEATURE + BORDER;
    localparam int BallXMax = SCREEN_W - FEATURE - BORDER;
    localparam int BallYMax = SCREEN_H - FEATURE - BORDER;

    localparam logic [COLOR_W-1:0] ColBlack = '0;
    localparam logic [COLOR_W-1:0] ColWhite = '1;
    localparam logic [COLOR_W-1:0] ColPink  = COLOR_W'(12'hE76);
    localparam logic [COLOR_W-1:0] ColRed   = COLOR_W'(12'hF00);

    state_e       state_q, state_d;
    logic         mode_q, mode_d;
    logic [7:0]   key_reg_q;
    logic         key_pend_q;
    logic [9:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic         dx_q, dx_d, dy_q, dy_d;
    logic [9:0]   p1_x_q, p1_x_d, p2_x_q, p2_x_d;
    logic [3:0]   speed_q, speed_d;
    logic [3:0]   ball_cnt_q, ball_cnt_d, cpu_cnt_q, cpu_cnt_d;
    logic [3:0]   score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic [7:0] key_act;
    logic       init_game, miss_p1, miss_p2;
    int         bx, by, p1x, p2x, px, py;

    assign bx  = int'(ball_x_q);
    assign by  = int'(ball_y_q);
    assign p1x = int'(p1_x_q);
    assign p2x = int'(p2_x_q);
    assign px  = int'(x_pos);
    assign py  = int'(y_pos);

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Only the latest key is held; a tick consumes whatever was pending before it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_reg_q  <= 8'h00;
            key_pend_q <= 1'b0;
        end else if (key_valid) begin
            key_reg_q  <= key_code;
            key_pend_q <= 1'b1;
        end else if (frame_tick) begin
            key_pend_q <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        p1_x_d     = p1_x_q;
        p2_x_d     = p2_x_q;
        speed_d    = speed_q;
        ball_cnt_d = ball_cnt_q;
        cpu_cnt_d  = cpu_cnt_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        init_game  = 1'b0;
        miss_p1    = 1'b0;
        miss_p2    = 1'b0;
        key_act    = key_pend_q ? key_reg_q : 8'h00;

        if (frame_tick) begin
            case (state_q)
                StReset: begin
                    init_game = 1'b1;
                    state_d   = StSelect;
                end
                StSelect: begin
                    if (key_act == KeyOne) begin
                        mode_d = 1'b0;
                    end else if (key_act == KeyTwo) begin
                        mode_d = 1'b1;
                    end else if (key_act == KeySpace) begin
                        state_d    = StPlay;
                        dx_d       = 1'b1;
                        dy_d       = 1'b1;
                        speed_d    = 4'(SPEED_INIT);
                        ball_cnt_d = '0;
                        cpu_cnt_d  = '0;
                    end
                end
                StPlay: begin
                    if (key_act == KeySpace) begin
                        state_d = StPause;
                    end else if (key_act == KeyEsc) begin
                        init_game = 1'b1;
                        state_d   = StReset;
                    end else begin
                        if (key_act == KeyD && p1x + BALL_SIZE <= PadMax) begin
                            p1_x_d = 10'(p1x + BALL_SIZE);
                        end else if (key_act == KeyA && p1x - BALL_SIZE >= PadMin) begin
                            p1_x_d = 10'(p1x - BALL_SIZE);
                        end

                        if (mode_q) begin
                            if (key_act == KeyL && p2x + BALL_SIZE <= PadMax) begin
                                p2_x_d = 10'(p2x + BALL_SIZE);
                            end else if (key_act == KeyJ && p2x - BALL_SIZE >= PadMin) begin
                                p2_x_d = 10'(p2x - BALL_SIZE);
                            end
                        end else if (cpu_cnt_q == 4'(CPU_PERIOD)) begin
                            cpu_cnt_d = '0;
                            if (bx > p2x && p2x + BALL_SIZE <= CpuMax) begin
                                p2_x_d = 10'(p2x + BALL_SIZE);
                            end else if (bx < p2x && p2x - BALL_SIZE >= CpuMin) begin
                                p2_x_d = 10'(p2x - BALL_SIZE);
                            end
                        end else begin
                            cpu_cnt_d = cpu_cnt_q + 4'd1;
                        end

                        if (ball_cnt_q == speed_q) begin
                            ball_cnt_d = '0;
                            if (dx_q) begin
                                if (bx <= BallXMax) ball_x_d = 10'(bx + BALL_SIZE);
                                else                dx_d     = 1'b0;
                            end else begin
                                if (bx >= BallMin) ball_x_d = 10'(bx - BALL_SIZE);
                                else               dx_d     = 1'b1;
                            end

                            if (dy_q) begin
                                if (abs_diff(bx, p1x) <= HalfPw && by == P1Y - BALL_SIZE) begin
                                    dy_d = 1'b0;
                                    if (speed_q > 4'(SPEED_MIN)) speed_d = speed_q - 4'd1;
                                end else if (by <= BallYMax) begin
                                    ball_y_d = 10'(by + BALL_SIZE);
                                end else begin
                                    miss_p1 = 1'b1;
                                end
                            end else begin
                                if (abs_diff(bx, p2x) <= HalfPw && by == P2Y + BALL_SIZE) begin
                                    dy_d = 1'b1;
                                    if (speed_q > 4'(SPEED_MIN)) speed_d = speed_q - 4'd1;
                                end else if (by >= BallMin) begin
                                    ball_y_d = 10'(by - BALL_SIZE);
                                end else begin
                                    miss_p2 = 1'b1;
                                end
                            end
                        end else begin
                            ball_cnt_d = ball_cnt_q + 4'd1;
                        end

                        // A miss recentres everything and serves toward the conceding player.
                        if (miss_p1 || miss_p2) begin
                            ball_x_d = 10'(CenX);
                            ball_y_d = 10'(CenY);
                            p1_x_d   = 10'(CenX);
                            p2_x_d   = 10'(CenX);
                            speed_d  = 4'(SPEED_INIT);
                            if (miss_p1) begin
                                score_p2_d = score_p2_q + 4'd1;
                                dy_d       = 1'b1;
                                state_d    = (score_p2_d == 4'(WIN_SCORE)) ? StOver : StScored;
                            end else begin
                                score_p1_d = score_p1_q + 4'd1;
                                dy_d       = 1'b0;
                                state_d    = (score_p1_d == 4'(WIN_SCORE)) ? StOver : StScored;
                            end
                        end
                    end
                end
                StPause, StScored: begin
                    if (key_act == KeySpace) begin
                        state_d = StPlay;
                    end else if (key_act == KeyEsc) begin
                        init_game = 1'b1;
                        state_d   = StReset;
                    end
                end
                StOver: begin
                    if (key_act == KeySpace || key_act == KeyEsc) begin
                        init_game = 1'b1;
                        state_d   = StReset;
                    end
                end
                default: begin
                    init_game = 1'b1;
                    state_d   = StReset;
                end
            endcase

            if (init_game) begin
                mode_d     = 1'b0;
                ball_x_d   = 10'(CenX);
                ball_y_d   = 10'(CenY);
                dx_d       = 1'b1;
                dy_d       = 1'b1;
                p1_x_d     = 10'(CenX);
                p2_x_d     = 10'(CenX);
                speed_d    = 4'(SPEED_INIT);
                ball_cnt_d = '0;
                cpu_cnt_d  = '0;
                score_p1_d = '0;
                score_p2_d = '0;
            end
        end
    end

    always_comb begin
        color_d = ColBlack;
        if (!active_zone) begin
            color_d = ColBlack;
        end else if (px < BORDER || px >= SCREEN_W - BORDER ||
                     py < BORDER || py >= SCREEN_H - BORDER) begin
            color_d = ColWhite;
        end else if (px < FEATURE || px >= SCREEN_W - FEATURE ||
                     py < FEATURE || py >= SCREEN_H - FEATURE) begin
            color_d = ColPink;
        end else if (abs_diff(px, p1x) <= HalfPw && abs_diff(py, P1Y) <= HalfPh) begin
            color_d = ColRed;
        end else if (abs_diff(px, p2x) <= HalfPw && abs_diff(py, P2Y) <= HalfPh) begin
            // The CPU paddle is hidden while the player is still choosing a mode.
            color_d = (state_q == StSelect && !mode_q) ? ColBlack : ColRed;
        end else if (abs_diff(px, bx) <= HalfBall && abs_diff(py, by) <= HalfBall) begin
            color_d = ColWhite;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StReset;
            mode_q     <= 1'b0;
            ball_x_q   <= 10'(CenX);
            ball_y_q   <= 10'(CenY);
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            p1_x_q     <= 10'(CenX);
            p2_x_q     <= 10'(CenX);
            speed_q    <= 4'(SPEED_INIT);
            ball_cnt_q <= '0;
            cpu_cnt_q  <= '0;
            score_p1_q <= '0;
            score_p2_q <= '0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            p1_x_q     <= p1_x_d;
            p2_x_q     <= p2_x_d;
            speed_q    <= speed_d;
            ball_cnt_q <= ball_cnt_d;
            cpu_cnt_q  <= cpu_cnt_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            color_q    <= color_d;
        end
    end

    assign color     = color_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign state     = state_q;
    assign game_over = (state_q == StOver);

endmodule
